alu_res_station: RTL

ALU reservation station between the instruction queue and the shared CDB/ROB. Holds dispatched ALU ops until both operands are ready, snooping the CDB for outstanding tags. Issues one ready op per cycle to an internal ALU and arbitrates for the CDB with the result. Flags the ROB entry complete through `set_rob_valid`.

---
 rtl/alu_res_station_pkg.sv | 36 +++
 rtl/rs_alu.sv | 31 +++
 rtl/alu_res_station.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/alu_res_station_pkg.sv
// Shared types and sizes for the ALU reservation station.
package alu_res_station_pkg;

  localparam int unsigned NUM_ENTRIES = 4;
  localparam int unsigned ROB_DEPTH   = 8;
  localparam int unsigned ROB_TAG_W   = 3;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned SLOT_IDX_W  = $clog2(NUM_ENTRIES);
  localparam int unsigned SHAMT_W     = 5;

  // ALU operation encoding shared with the decoder
  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  // One reservation station slot
  typedef struct packed {
    logic                 valid;
    alu_ops               op;
    logic [ROB_TAG_W-1:0] tag;
    logic [XLEN-1:0]      vj;
    logic [XLEN-1:0]      vk;
    logic [ROB_TAG_W-1:0] qj;
    logic [ROB_TAG_W-1:0] qk;
    logic                 qj_busy;
    logic                 qk_busy;
  } rs_entry_t;

endpackage

// File: rtl/rs_alu.sv
// Combinational integer ALU used by the reservation station issue path.
module rs_alu
  import alu_res_station_pkg::*;
(
  input  alu_ops          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] f
);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = b[SHAMT_W-1:0];

  // Operation select; shifts use only the low five bits of b
  always_comb begin
    f = '0;
    case (op)
      alu_add: f = a + b;
      alu_sub: f = a - b;
      alu_xor: f = a ^ b;
      alu_or:  f = a | b;
      alu_and: f = a & b;
      alu_sll: f = a << shamt;
      alu_srl: f = a >> shamt;
      alu_sra: f = XLEN'($signed(a) >>> shamt);
      default: f = '0;
    endcase
  end

endmodule

// File: rtl/alu_res_station.sv
// ALU reservation station: holds dispatched ops until operands are ready,
// snoops the CDB, issues one op per cycle and broadcasts the result.
module alu_res_station
  import alu_res_station_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs_load,
  input  alu_ops               alu_op,
  input  logic [ROB_TAG_W-1:0] rob_tag,
  input  logic [XLEN-1:0]      vj,
  input  logic [XLEN-1:0]      vk,
  input  logic [ROB_TAG_W-1:0] qj,
  input  logic [ROB_TAG_W-1:0] qk,
  input  logic                 qj_busy,
  input  logic                 qk_busy,
  output logic                 rs_full,
  input  logic                 cdb_valid,
  input  logic [ROB_TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]      cdb_data,
  output logic                 cdb_req,
  input  logic                 cdb_grant,
  output logic [ROB_TAG_W-1:0] cdb_tag_out,
  output logic [XLEN-1:0]      cdb_data_out,
  output logic                 set_rob_valid [ROB_DEPTH],
  input  logic                 branch_mispredict
);

  rs_entry_t            slots_q [NUM_ENTRIES];
  rs_entry_t            slots_d [NUM_ENTRIES];
  logic                 res_valid_q, res_valid_d;
  logic [ROB_TAG_W-1:0] res_tag_q, res_tag_d;
  logic [XLEN-1:0]      res_data_q, res_data_d;

  logic [NUM_ENTRIES-1:0] slot_valid;
  logic [NUM_ENTRIES-1:0] slot_ready;
  logic [SLOT_IDX_W:0]    free_sel;
  logic [SLOT_IDX_W:0]    ready_sel;
  logic                   drain;
  logic                   issue;
  rs_entry_t              issue_entry;
  rs_entry_t              new_entry;
  logic [XLEN-1:0]        alu_f;

  // Lowest set bit of v; MSB of the result flags that one was found
  function automatic logic [SLOT_IDX_W:0] lowest_set(input logic [NUM_ENTRIES-1:0] v);
    logic [SLOT_IDX_W:0] r;
    r = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (v[i]) r = {1'b1, SLOT_IDX_W'(i)};
    end
    return r;
  endfunction

  // Per-slot occupancy and readiness from registered state
  always_comb begin
    slot_valid = '0;
    slot_ready = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      slot_valid[i] = slots_q[i].valid;
      slot_ready[i] = slots_q[i].valid && !slots_q[i].qj_busy && !slots_q[i].qk_busy;
    end
  end

  assign rs_full     = &slot_valid;
  assign free_sel    = lowest_set(~slot_valid);
  assign ready_sel   = lowest_set(slot_ready);
  assign drain       = res_valid_q && cdb_grant;
  assign issue       = ready_sel[SLOT_IDX_W] && (!res_valid_q || drain);
  assign issue_entry = slots_q[ready_sel[SLOT_IDX_W-1:0]];

  rs_alu u_alu (
    .op (issue_entry.op),
    .a  (issue_entry.vj),
    .b  (issue_entry.vk),
    .f  (alu_f)
  );

  // Incoming dispatch, with CDB bypass so a same-cycle broadcast is not lost
  always_comb begin
    new_entry         = '0;
    new_entry.valid   = 1'b1;
    new_entry.op      = alu_op;
    new_entry.tag     = rob_tag;
    new_entry.vj      = vj;
    new_entry.vk      = vk;
    new_entry.qj      = qj;
    new_entry.qk      = qk;
    new_entry.qj_busy = qj_busy;
    new_entry.qk_busy = qk_busy;
    if (cdb_valid && qj_busy && (qj == cdb_tag)) begin
      new_entry.vj      = cdb_data;
      new_entry.qj_busy = 1'b0;
    end
    if (cdb_valid && qk_busy && (qk == cdb_tag)) begin
      new_entry.vk      = cdb_data;
      new_entry.qk_busy = 1'b0;
    end
  end

  // Next state: snoop, issue, dispatch, then flush overrides everything
  always_comb begin
    slots_d     = slots_q;
    res_valid_d = res_valid_q;
    res_tag_d   = res_tag_q;
    res_data_d  = res_data_q;

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (cdb_valid && slots_q[i].valid) begin
        if (slots_q[i].qj_busy && (slots_q[i].qj == cdb_tag)) begin
          slots_d[i].vj      = cdb_data;
          slots_d[i].qj_busy = 1'b0;
        end
        if (slots_q[i].qk_busy && (slots_q[i].qk == cdb_tag)) begin
          slots_d[i].vk      = cdb_data;
          slots_d[i].qk_busy = 1'b0;
        end
      end
    end

    if (issue) begin
      slots_d[ready_sel[SLOT_IDX_W-1:0]].valid = 1'b0;
      res_valid_d = 1'b1;
      res_tag_d   = issue_entry.tag;
      res_data_d  = alu_f;
    end else if (drain) begin
      res_valid_d = 1'b0;
    end

    if (rs_load && !rs_full) begin
      slots_d[free_sel[SLOT_IDX_W-1:0]] = new_entry;
    end

    if (branch_mispredict) begin
      for (int i = 0; i < NUM_ENTRIES; i++) slots_d[i].valid = 1'b0;
      res_valid_d = 1'b0;
      res_tag_d   = '0;
      res_data_d  = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) slots_q[i] <= '0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_data_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) slots_q[i] <= slots_d[i];
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
      res_data_q  <= res_data_d;
    end
  end

  assign cdb_req      = res_valid_q;
  assign cdb_tag_out  = res_tag_q;
  assign cdb_data_out = res_data_q;

  // One-hot ROB completion on a granted broadcast, suppressed during flush
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) begin
      set_rob_valid[i] = drain && !branch_mispredict && (res_tag_q == ROB_TAG_W'(i));
    end
  end

endmodule
